// File: rtl/counter_job_scheduler_if.sv
// Requester, result and counter-pin signals of counter_job_scheduler.
// The slave side is the scheduler; the master side is the requester logic
// together with the shared counter it steers.
interface counter_job_scheduler_if #(
  parameter int unsigned NREQ = 2,
  parameter int unsigned CW   = 4,
  parameter int unsigned LW   = 4
);
  logic [NREQ-1:0]    req;
  logic [2*NREQ-1:0]  req_mode;
  logic [CW*NREQ-1:0] req_d;
  logic [LW*NREQ-1:0] req_len;
  logic [NREQ-1:0]    gnt;
  logic [NREQ-1:0]    done;
  logic [CW-1:0]      result;
  logic               result_rco;
  logic               busy;
  logic               cnt_enable;
  logic [1:0]         cnt_mode;
  logic [CW-1:0]      cnt_d;
  logic [CW-1:0]      cnt_q;
  logic               cnt_rco;

  modport master (
    output req, req_mode, req_d, req_len, cnt_q, cnt_rco,
    input  gnt, done, result, result_rco, busy, cnt_enable, cnt_mode, cnt_d
  );

  modport slave (
    input  req, req_mode, req_d, req_len, cnt_q, cnt_rco,
    output gnt, done, result, result_rco, busy, cnt_enable, cnt_mode, cnt_d
  );
endinterface

// File: rtl/counter_job_scheduler.sv
// Round-robin job scheduler for one shared multi-mode counter.
// Each granted job loads its seed, runs its mode for len cycles, then the
// final counter value and sticky ripple-carry are returned to the owner.
module counter_job_scheduler #(
  parameter int unsigned NREQ = 2,
  parameter int unsigned CW   = 4,
  parameter int unsigned LW   = 4
) (
  input logic                    clk,
  input logic                    reset,
  counter_job_scheduler_if.slave bus
);
  localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_RUN, S_CAPT, S_RESP} state_t;

  state_t          state_q, state_d;
  logic [IW-1:0]   last_q, last_d;
  logic [IW-1:0]   owner_q, owner_d;
  logic [1:0]      mode_q, mode_d;
  logic [CW-1:0]   seed_q, seed_d;
  logic [LW-1:0]   len_q, len_d;
  logic            acc_q, acc_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic [NREQ-1:0] done_q, done_d;
  logic [CW-1:0]   result_q, result_d;
  logic            result_rco_q, result_rco_d;
  logic            cnt_enable_q, cnt_enable_d;
  logic [1:0]      cnt_mode_q, cnt_mode_d;
  logic [CW-1:0]   cnt_d_q, cnt_d_d;

  logic [IW-1:0]   win;
  logic [IW-1:0]   cand;
  logic            found;

  // Round-robin pick: first set request scanning upward from last_grant+1.
  always_comb begin
    win   = last_q;
    cand  = '0;
    found = 1'b0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      cand = IW'((32'(last_q) + k) % NREQ);
      if (!found && bus.req[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end
  end

  // Next-state and next-output logic; every output is the value for the
  // state being entered, so the registered pins line up with the state.
  always_comb begin
    state_d      = state_q;
    last_d       = last_q;
    owner_d      = owner_q;
    mode_d       = mode_q;
    seed_d       = seed_q;
    len_d        = len_q;
    acc_d        = acc_q;
    gnt_d        = '0;
    done_d       = '0;
    result_d     = result_q;
    result_rco_d = result_rco_q;
    cnt_enable_d = cnt_enable_q;
    cnt_mode_d   = cnt_mode_q;
    cnt_d_d      = cnt_d_q;
    case (state_q)
      S_IDLE: begin
        cnt_enable_d = 1'b0;
        if (|bus.req) begin
          state_d      = S_LOAD;
          last_d       = win;
          owner_d      = win;
          mode_d       = bus.req_mode[2*win +: 2];
          seed_d       = bus.req_d[CW*win +: CW];
          len_d        = bus.req_len[LW*win +: LW];
          gnt_d[win]   = 1'b1;
          cnt_enable_d = 1'b1;
          cnt_mode_d   = 2'b11;
          cnt_d_d      = bus.req_d[CW*win +: CW];
        end
      end
      S_LOAD: begin
        acc_d = 1'b0;
        if (mode_q != 2'b11 && len_q != '0) begin
          state_d      = S_RUN;
          cnt_enable_d = 1'b1;
          cnt_mode_d   = mode_q;
          cnt_d_d      = seed_q;
        end else begin
          state_d      = S_CAPT;
          cnt_enable_d = 1'b0;
        end
      end
      S_RUN: begin
        // len_q doubles as the remaining-run-cycles down-counter.
        acc_d = acc_q | bus.cnt_rco;
        len_d = len_q - LW'(1);
        if (len_q == LW'(1)) begin
          state_d      = S_CAPT;
          cnt_enable_d = 1'b0;
        end
      end
      S_CAPT: begin
        acc_d           = acc_q | bus.cnt_rco;
        result_d        = bus.cnt_q;
        result_rco_d    = acc_q | bus.cnt_rco;
        done_d[owner_q] = 1'b1;
        state_d         = S_RESP;
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d      = S_IDLE;
        cnt_enable_d = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      last_q       <= IW'(NREQ - 1);
      owner_q      <= '0;
      mode_q       <= '0;
      seed_q       <= '0;
      len_q        <= '0;
      acc_q        <= 1'b0;
      gnt_q        <= '0;
      done_q       <= '0;
      result_q     <= '0;
      result_rco_q <= 1'b0;
      cnt_enable_q <= 1'b0;
      cnt_mode_q   <= 2'b00;
      cnt_d_q      <= '0;
    end else begin
      state_q      <= state_d;
      last_q       <= last_d;
      owner_q      <= owner_d;
      mode_q       <= mode_d;
      seed_q       <= seed_d;
      len_q        <= len_d;
      acc_q        <= acc_d;
      gnt_q        <= gnt_d;
      done_q       <= done_d;
      result_q     <= result_d;
      result_rco_q <= result_rco_d;
      cnt_enable_q <= cnt_enable_d;
      cnt_mode_q   <= cnt_mode_d;
      cnt_d_q      <= cnt_d_d;
    end
  end

  assign bus.gnt        = gnt_q;
  assign bus.done       = done_q;
  assign bus.result     = result_q;
  assign bus.result_rco = result_rco_q;
  assign bus.busy       = (state_q != S_IDLE);
  assign bus.cnt_enable = cnt_enable_q;
  assign bus.cnt_mode   = cnt_mode_q;
  assign bus.cnt_d      = cnt_d_q;
endmodule
